// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer: turns raw decoder requests into registered, mutually exclusive actuator commands.
// Build option IRRIG_DEBOUNCE_EN swaps the one-cycle input registers for debounce filters.
module irrigation_sequencer #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN_ON     = 8,
  parameter int MAX_ON     = 64,
  parameter int MIN_OFF    = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bs_req,
  input  logic       vs_req,
  input  logic       ve_req,
  input  logic       err,
  input  logic       fault_clr,
  output logic       Bs,
  output logic       Vs,
  output logic       Ve,
  output logic       Al,
  output logic       working,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPRAY = 3'd1,
    DRIP  = 3'd2,
    REST  = 3'd3,
    FAULT = 3'd4
  } st_e;

  logic [2:0] req_raw;
  logic [2:0] req_f;

  assign req_raw = {ve_req, vs_req, bs_req};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_filt
      logic f_q;
`ifdef IRRIG_DEBOUNCE_EN
      logic [CNT_W-1:0] deb_q, deb_d;
      logic             f_d;

      // The counter holds the number of earlier mismatching samples; the
      // current mismatching sample completes the run and flips the output.
      always_comb begin
        deb_d = '0;
        f_d   = f_q;
        if (req_raw[gi] != f_q) begin
          if (deb_q == CNT_W'(DEB_CYCLES - 2)) f_d = req_raw[gi];
          else                                 deb_d = deb_q + 1'b1;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          deb_q <= '0;
          f_q   <= 1'b0;
        end else begin
          deb_q <= deb_d;
          f_q   <= f_d;
        end
      end
`else
      always_ff @(posedge clock) begin
        if (reset) f_q <= 1'b0;
        else       f_q <= req_raw[gi];
      end
`endif
      assign req_f[gi] = f_q;
    end
  endgenerate

  logic             bs_f, vs_f, ve_f;
  logic             err_q;
  st_e              st_q, st_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bs_q, vs_q, ve_q, al_q;

  assign bs_f = req_f[0];
  assign vs_f = req_f[1];
  assign ve_f = req_f[2];

  always_comb begin
    st_d   = st_q;
    last_d = last_q;
    if (err_q) begin
      st_d = FAULT;
    end else begin
      case (st_q)
        FAULT: if (fault_clr) st_d = IDLE;
        IDLE: begin
          // On a tie the requester that was not served last wins.
          if (bs_f && (!vs_f || last_q)) begin
            st_d   = SPRAY;
            last_d = 1'b0;
          end else if (vs_f) begin
            st_d   = DRIP;
            last_d = 1'b1;
          end
        end
        SPRAY: if ((!bs_f && cnt_q >= CNT_W'(MIN_ON - 1)) || cnt_q == CNT_W'(MAX_ON - 1)) st_d = REST;
        DRIP:  if ((!vs_f && cnt_q >= CNT_W'(MIN_ON - 1)) || cnt_q == CNT_W'(MAX_ON - 1)) st_d = REST;
        REST:  if (cnt_q == CNT_W'(MIN_OFF - 1)) st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (st_d != st_q)   cnt_d = '0;
    else if (~&cnt_q)   cnt_d = cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so they change on the same edge as st_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q  <= 1'b0;
      st_q   <= IDLE;
      last_q <= 1'b1;
      cnt_q  <= '0;
      bs_q   <= 1'b0;
      vs_q   <= 1'b0;
      ve_q   <= 1'b0;
      al_q   <= 1'b0;
    end else begin
      err_q  <= err;
      st_q   <= st_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      bs_q   <= (st_d == SPRAY);
      vs_q   <= (st_d == DRIP);
      ve_q   <= ve_f & (st_d != FAULT);
      al_q   <= (st_d == FAULT);
    end
  end

  assign Bs      = bs_q;
  assign Vs      = vs_q;
  assign Ve      = ve_q;
  assign Al      = al_q;
  assign working = ~al_q;
  assign state   = st_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer (default build): latency, dwell limits, round-robin, fault and reset.
module tb_irrigation_sequencer;

  logic       clock = 1'b0;
  logic       reset, bs_req, vs_req, ve_req, err, fault_clr;
  logic       Bs, Vs, Ve, Al, working;
  logic [2:0] state;
  int         errors = 0;
  int         checks = 0;

  irrigation_sequencer dut (
    .clock(clock), .reset(reset), .bs_req(bs_req), .vs_req(vs_req), .ve_req(ve_req),
    .err(err), .fault_clr(fault_clr), .Bs(Bs), .Vs(Vs), .Ve(Ve), .Al(Al),
    .working(working), .state(state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset) check("bs_vs_exclusive", {7'd0, Bs & Vs}, 8'd0);
  end

  initial begin
    reset = 1'b1; bs_req = 0; vs_req = 0; ve_req = 0; err = 0; fault_clr = 0;
    tick(2);
    check("rst_Bs", Bs, 0); check("rst_Vs", Vs, 0); check("rst_Ve", Ve, 0);
    check("rst_Al", Al, 0); check("rst_working", working, 1); check("rst_state", state, 0);

    // Single sprinkler request, dropped early: MIN_ON holds it for 8 cycles.
    reset = 1'b0; bs_req = 1'b1;
    tick(1); check("lat_n1_Bs", Bs, 0); check("lat_n1_state", state, 0);
    tick(1); check("lat_n2_Bs", Bs, 1); check("lat_n2_state", state, 1);
    tick(2); bs_req = 1'b0;
    tick(5); check("minon_hold_Bs", Bs, 1); check("minon_hold_state", state, 1);
    tick(1); check("minon_rest_Bs", Bs, 0); check("minon_rest_state", state, 3);
    tick(3); check("rest_last_state", state, 3);
    tick(1); check("rest_idle_state", state, 0);

    // Both requests held: drip wins the tie (sprinkler served last), forced REST at MAX_ON.
    bs_req = 1'b1; vs_req = 1'b1;
    tick(2);  check("rr1_Vs", Vs, 1); check("rr1_state", state, 2);
    tick(63); check("maxon_drip_state", state, 2);
    tick(1);  check("maxon_rest_state", state, 3); check("maxon_rest_Vs", Vs, 0);
    tick(4);  check("rr_idle_state", state, 0);
    tick(1);  check("rr2_state", state, 1); check("rr2_Bs", Bs, 1);
    tick(63); check("maxon_spray_state", state, 1);
    tick(1);  check("maxon_spray_rest", state, 3);
    bs_req = 1'b0; vs_req = 1'b0;
    tick(4);  check("rr_end_idle", state, 0); check("rr_end_Bs", Bs, 0);

    // Three-cycle drip glitch passes straight through without debounce.
    vs_req = 1'b1;
    tick(1); check("glitch_idle", state, 0);
    tick(1); check("glitch_Vs", Vs, 1); check("glitch_state", state, 2);
    tick(1); vs_req = 1'b0;
    tick(6); check("glitch_hold_Vs", Vs, 1);
    tick(1); check("glitch_rest", state, 3);
    tick(4); check("glitch_idle2", state, 0);

    // One-cycle err pulse during SPRAY with inlet valve on.
    bs_req = 1'b1; ve_req = 1'b1;
    tick(2); check("spray_Bs", Bs, 1); check("spray_Ve", Ve, 1); check("spray_state", state, 1);
    tick(2); err = 1'b1;
    tick(1); check("err_q_Bs", Bs, 1); err = 1'b0;
    tick(1); check("fault_Bs", Bs, 0); check("fault_Ve", Ve, 0); check("fault_Al", Al, 1);
    check("fault_working", working, 0); check("fault_state", state, 4);
    tick(1); check("fault_latched", state, 4);
    fault_clr = 1'b1; bs_req = 1'b0; ve_req = 1'b0;
    tick(1); check("clr_state", state, 0); check("clr_Al", Al, 0);
    check("clr_working", working, 1); check("clr_Bs", Bs, 0);

    // fault_clr while err is still high keeps FAULT.
    err = 1'b1;
    tick(3); check("clr_err_state_a", state, 4);
    tick(2); check("clr_err_state_b", state, 4);
    err = 1'b0;
    tick(1); check("clr_errq_state", state, 4); check("clr_errq_Al", Al, 1);
    tick(1); check("clr_ok_state", state, 0);
    fault_clr = 1'b0;

    // Reset mid-DRIP, then reset overriding err.
    vs_req = 1'b1; ve_req = 1'b1;
    tick(2); check("drip_Vs", Vs, 1); check("drip_Ve", Ve, 1); check("drip_state", state, 2);
    tick(1); reset = 1'b1;
    tick(1); check("mrst_Vs", Vs, 0); check("mrst_Ve", Ve, 0); check("mrst_Al", Al, 0);
    check("mrst_working", working, 1); check("mrst_state", state, 0);
    err = 1'b1;
    tick(1); check("rst_err_state", state, 0); check("rst_err_Al", Al, 0);
    reset = 1'b0; err = 1'b0; vs_req = 1'b0; ve_req = 1'b0;
    tick(2); check("post_rst_state", state, 0); check("post_rst_Ve", Ve, 0);

    // After reset last=1, so the sprinkler wins the first tie.
    bs_req = 1'b1; vs_req = 1'b1;
    tick(2); check("tie_state", state, 1); check("tie_Bs", Bs, 1); check("tie_Vs", Vs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irrigation_sequencer.md
# irrigation_sequencer

Sequential controller placed between the combinational irrigation decoder and the physical actuators. It takes the decoder's raw requests (sprinkler pump, drip valve, inlet valve, measurement error) and produces glitch-free, registered actuator commands. It arbitrates the shared water supply so that sprinkler and drip never run together, and enforces minimum/maximum run and rest times. Measurement errors are latched into a fault state that needs an explicit operator clear.

## Interface
- `DEB_CYCLES`, 4: consecutive stable samples required before a filtered request changes (debounce builds only).
- `MIN_ON`, 8: minimum cycles in SPRAY or DRIP before a dropped request is honoured.
- `MAX_ON`, 64: maximum cycles in SPRAY or DRIP before a forced REST.
- `MIN_OFF`, 4: cycles spent in REST.
- `CNT_W`, 8: dwell/debounce counter width. Requires MIN_ON < MAX_ON < 2^CNT_W.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `bs_req` in 1: sprinkler request from decoder.
- `vs_req` in 1: drip request from decoder.
- `ve_req` in 1: inlet-valve request from decoder.
- `err` in 1: level-sensor inconsistency from decoder.
- `fault_clr` in 1: operator clear, sampled level.
- `Bs` out 1: sprinkler pump command.
- `Vs` out 1: drip valve command.
- `Ve` out 1: inlet valve command.
- `Al` out 1: alarm; high in FAULT.
- `working` out 1: inverse of FAULT.
- `state` out 3: encoded state. IDLE=0, SPRAY=1, DRIP=2, REST=3, FAULT=4.

## Operation
- Input stage:
  - `bs_req`, `vs_req` and `ve_req` each pass through a filter giving `bs_f`, `vs_f`, `ve_f`.
  - `err` is never debounced. It is registered once to `err_q`.
- State register `st`. `last` records the last served requester (0 = sprinkler, 1 = drip). Dwell counter `cnt` clears on every state change and otherwise increments, saturating at 2^CNT_W−1.
- Transitions, evaluated in priority order on each edge:
  - Any state, `err_q`=1 → FAULT.
  - FAULT → IDLE when `err_q`=0 and `fault_clr`=1 in the same cycle. Otherwise stay. `fault_clr` has no effect outside FAULT.
  - IDLE:
    - Only `bs_f` set → SPRAY.
    - Only `vs_f` set → DRIP.
    - Both set → grant the requester not equal to `last` (round-robin).
    - On grant, set `last` to the granted requester.
  - SPRAY or DRIP → REST when either:
    - the own request is 0 and `cnt` ≥ MIN_ON−1, or
    - `cnt` = MAX_ON−1, regardless of request.
  - REST → IDLE when `cnt` = MIN_OFF−1.
- Outputs decode from `st` and are registered:
  - `Bs` = (st==SPRAY).
  - `Vs` = (st==DRIP).
  - `Al` = (st==FAULT).
  - `working` = ~Al.
  - `Ve` = `ve_f` & (st!=FAULT). Ve is independent of the irrigation arbitration.
- `Bs` and `Vs` are never high in the same cycle. This is a hard invariant.

## Timing
- Reset values: st=IDLE, last=1 (so the sprinkler wins the first tie), cnt=0, all filters 0. Outputs: Bs=0, Vs=0, Ve=0, Al=0, working=1, state=0.
- Reset asserted mid-run drops Bs/Vs/Ve at the next edge. Reset overrides err.
- Request latency:
  - Debounce build: raw request stable from edge n → filtered at edge n+DEB_CYCLES−1 → state and outputs at n+DEB_CYCLES.
  - Non-debounce build: outputs at n+2.
- Fault latency: `err` high before edge n → `err_q` at edge n → FAULT, with Bs/Vs/Ve low, at edge n+1. This holds in both builds.
- A single-cycle `err` pulse still latches FAULT.
- Forced REST at MAX_ON happens even when the request stays asserted. After MIN_OFF, the round-robin gives a waiting other requester the grant.
- Simultaneous SPRAY request drop and `err`: FAULT wins.

## Configuration
- `IRRIG_DEBOUNCE_EN` defined:
  - Each request filter keeps a counter of consecutive cycles where the raw value differs from the filtered value. The counter resets when they agree.
  - The filtered value flips when the counter reaches DEB_CYCLES−1.
- Undefined:
  - The filter is a single register (filtered = raw delayed by one cycle). DEB_CYCLES is ignored and no debounce counters are synthesised.

## Test plan
- Reset, then `bs_req`=1 held (DEB_CYCLES=4, debounce build) → Bs=1 exactly 4 edges after the request, state=1. Drop `bs_req` at cnt=2 → Bs stays high until MIN_ON=8 is satisfied, then REST for 4 cycles, then IDLE.
- `bs_req` and `vs_req` both held high → alternation SPRAY(64) → REST(4) → DRIP(64) → REST(4) → SPRAY. Bs&Vs never high together.
- 3-cycle `vs_req` glitch in debounce build → Vs never asserts. Non-debounce build → DRIP for MIN_ON cycles.
- During SPRAY with `ve_req`=1, pulse `err` for 1 cycle → Bs=0, Ve=0, Al=1, working=0 one edge after `err_q`. Assert `fault_clr` while err=0 → IDLE next edge.
- `fault_clr` asserted while `err` is still high → remain in FAULT. `reset` during DRIP → all outputs return to reset values next edge.
